// File: rtl/mov_seq_ctrl_pkg.sv
// mov_seq_ctrl_pkg: opcodes, FSM state encoding and decode helper shared by the transfer sequencer.
package mov_seq_ctrl_pkg;

    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_MVI  = 4'b1010;
    localparam logic [3:0] OP_XCHG = 4'b1100;

    typedef enum logic [2:0] {
        IDLE, RD, CAP_A, CAP_B, HOLD, WR_A, WR_B, DONE
    } state_t;

    // Opcodes that need the register file read phase before writing.
    function automatic logic is_read_op(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_XCHG);
    endfunction

endpackage

// File: rtl/mov_seq_ctrl_settle_timer.sv
// mov_seq_ctrl_settle_timer: HOLD_CYC down-counter timing the settle phase between capture and write.
// Ports: clk, rst_n (async active-low), i_start (load HOLD_CYC), o_expire (high during the last settle cycle).
module mov_seq_ctrl_settle_timer #(
    parameter int HOLD_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_expire
);

    localparam int CW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

    logic [CW-1:0] r_cnt;

    // Counter reaches zero on the edge that leaves HOLD, so it is clear between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_start)
            r_cnt <= CW'(HOLD_CYC);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_expire = (r_cnt == CW'(1));

endmodule

// File: rtl/mov_seq_ctrl.sv
// mov_seq_ctrl: sequencer for MOV/MVI/XCHG register transfers driving the register file ports.
// Ports: clk, rst_n (async active-low); instruction handshake i_instr_valid/o_instr_ready with
// i_instr_op/rd/rs/imm; register file o_rf_raddr, i_rf_rdata (one-cycle latency), o_rf_we/waddr/wdata;
// status o_busy, o_done (one-cycle pulse), o_err (pulse with o_done for unsupported opcodes).
module mov_seq_ctrl
    import mov_seq_ctrl_pkg::*;
#(
    parameter int HOLD_CYC = 3,
    parameter int DW       = 8,
    parameter int AW       = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_instr_valid,
    output logic          o_instr_ready,
    input  logic [3:0]    i_instr_op,
    input  logic [AW-1:0] i_instr_rd,
    input  logic [AW-1:0] i_instr_rs,
    input  logic [DW-1:0] i_instr_imm,
    output logic [AW-1:0] o_rf_raddr,
    input  logic [DW-1:0] i_rf_rdata,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_waddr,
    output logic [DW-1:0] o_rf_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam state_t AFTER_CAP = (HOLD_CYC == 0) ? WR_A : HOLD;

    state_t        r_state, w_next;
    logic [3:0]    r_op;
    logic [AW-1:0] r_rd, r_rs;
    logic [DW-1:0] r_imm, r_tmp_a, r_tmp_b;
    logic          w_accept, w_expire, w_hold_start;

    assign w_accept     = (r_state == IDLE) && i_instr_valid;
    assign w_hold_start = (w_next == HOLD) && (r_state != HOLD);

    mov_seq_ctrl_settle_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_hold_start),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Fields are latched only at the handshake; tmp_a/tmp_b capture the data returned for the
    // address presented one state earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_rd    <= '0;
            r_rs    <= '0;
            r_imm   <= '0;
            r_tmp_a <= '0;
            r_tmp_b <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= i_instr_op;
                r_rd  <= i_instr_rd;
                r_rs  <= i_instr_rs;
                r_imm <= i_instr_imm;
            end
            if (r_state == CAP_A)
                r_tmp_a <= i_rf_rdata;
            if (r_state == CAP_B)
                r_tmp_b <= i_rf_rdata;
        end
    end

    // RD is the common decode state after accept; only MOV/XCHG present a read address there.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_instr_valid ? RD : IDLE;
            RD:      w_next = is_read_op(r_op) ? CAP_A : ((r_op == OP_MVI) ? WR_A : DONE);
            CAP_A:   w_next = (r_op == OP_XCHG) ? CAP_B : AFTER_CAP;
            CAP_B:   w_next = AFTER_CAP;
            HOLD:    w_next = w_expire ? WR_A : HOLD;
            WR_A:    w_next = (r_op == OP_XCHG) ? WR_B : DONE;
            WR_B:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_rf_raddr = '0;
        o_rf_we    = 1'b0;
        o_rf_waddr = '0;
        o_rf_wdata = '0;
        case (r_state)
            RD:      o_rf_raddr = is_read_op(r_op) ? r_rs : '0;
            CAP_A:   o_rf_raddr = (r_op == OP_XCHG) ? r_rd : '0;
            WR_A: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_rd;
                o_rf_wdata = (r_op == OP_MVI) ? r_imm : r_tmp_a;
            end
            WR_B: begin
                o_rf_we    = 1'b1;
                o_rf_waddr = r_rs;
                o_rf_wdata = r_tmp_b;
            end
            default: o_rf_raddr = '0;
        endcase
    end

    assign o_instr_ready = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign o_err         = (r_state == DONE) && !is_read_op(r_op) && (r_op != OP_MVI);

endmodule

// File: tb/tb_mov_seq_ctrl.sv
// tb_mov_seq_ctrl: directed self-checking bench for mov_seq_ctrl with a register file model.
module tb_mov_seq_ctrl;
    import mov_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_instr_valid;
    logic       o_instr_ready;
    logic [3:0] i_instr_op;
    logic [2:0] i_instr_rd, i_instr_rs;
    logic [7:0] i_instr_imm;
    logic [2:0] o_rf_raddr;
    logic [7:0] i_rf_rdata;
    logic       o_rf_we;
    logic [2:0] o_rf_waddr;
    logic [7:0] o_rf_wdata;
    logic       o_busy, o_done, o_err;

    logic [7:0] rf [0:7];
    logic       pl_we;
    logic [2:0] pl_a;
    logic [7:0] pl_d;

    int n_chk = 0;
    int n_err = 0;

    logic [10:0] m_we, m_done, m_err, m_busy, m_ready, m_rd;
    logic [2:0]  wa [0:10];
    logic [7:0]  wd [0:10];
    logic [2:0]  ra [0:10];

    always #5 clk = ~clk;

    mov_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr_valid (i_instr_valid),
        .o_instr_ready (o_instr_ready),
        .i_instr_op    (i_instr_op),
        .i_instr_rd    (i_instr_rd),
        .i_instr_rs    (i_instr_rs),
        .i_instr_imm   (i_instr_imm),
        .o_rf_raddr    (o_rf_raddr),
        .i_rf_rdata    (i_rf_rdata),
        .o_rf_we       (o_rf_we),
        .o_rf_waddr    (o_rf_waddr),
        .o_rf_wdata    (o_rf_wdata),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always @(posedge clk) begin
        i_rf_rdata <= rf[o_rf_raddr];
        if (pl_we)
            rf[pl_a] <= pl_d;
        else if (o_rf_we)
            rf[o_rf_waddr] <= o_rf_wdata;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Returns #1 after the accepting edge E0 (state RD, trace index 0).
    task automatic start_op(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s, input logic [7:0] im);
        int n = 0;
        while (!o_instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, o_instr_ready}, 32'd1);
        i_instr_op    = op;
        i_instr_rd    = d;
        i_instr_rs    = s;
        i_instr_imm   = im;
        i_instr_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    // Bit t of each mask is the output seen after edge E0+t.
    task automatic trace(input bit hold);
        if (!hold)
            i_instr_valid = 1'b0;
        for (int t = 0; t <= 10; t++) begin
            m_we[t]    = o_rf_we;
            m_done[t]  = o_done;
            m_err[t]   = o_err;
            m_busy[t]  = o_busy;
            m_ready[t] = o_instr_ready;
            m_rd[t]    = (o_rf_raddr != 3'd0);
            wa[t]      = o_rf_waddr;
            wd[t]      = o_rf_wdata;
            ra[t]      = o_rf_raddr;
            if (hold && t == 2) begin
                i_instr_rd  = 3'd0;
                i_instr_rs  = 3'd1;
                i_instr_imm = 8'hFF;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        i_instr_valid = 1'b0;
        i_instr_op    = 4'd0;
        i_instr_rd    = 3'd0;
        i_instr_rs    = 3'd0;
        i_instr_imm   = 8'd0;
        pl_we         = 1'b0;
        pl_a          = 3'd0;
        pl_d          = 8'd0;
        #12;
        chk("rst_outputs", {8'd0, o_busy, o_rf_we, o_done, o_err, o_rf_raddr, o_rf_waddr, o_rf_wdata}, 32'd0);
        chk("rst_ready", {31'd0, o_instr_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        preload(3'd3, 8'hA5);
        preload(3'd2, 8'h12);
        preload(3'd5, 8'h34);

        start_op(OP_MOV, 3'd1, 3'd3, 8'h00);
        trace(1'b0);
        chk("mov_we",    {21'd0, m_we},   32'h020);
        chk("mov_done",  {21'd0, m_done}, 32'h040);
        chk("mov_err",   {21'd0, m_err},  32'h000);
        chk("mov_busy",  {21'd0, m_busy}, 32'h07F);
        chk("mov_raddr_mask", {21'd0, m_rd}, 32'h001);
        chk("mov_raddr", {29'd0, ra[0]}, 32'd3);
        chk("mov_waddr", {29'd0, wa[5]}, 32'd1);
        chk("mov_wdata", {24'd0, wd[5]}, 32'hA5);
        chk("mov_r1",    {24'd0, rf[1]}, 32'hA5);

        start_op(OP_XCHG, 3'd2, 3'd5, 8'h00);
        trace(1'b0);
        chk("xchg_we",    {21'd0, m_we},   32'h0C0);
        chk("xchg_done",  {21'd0, m_done}, 32'h100);
        chk("xchg_raddr_mask", {21'd0, m_rd}, 32'h003);
        chk("xchg_raddr0", {29'd0, ra[0]}, 32'd5);
        chk("xchg_raddr1", {29'd0, ra[1]}, 32'd2);
        chk("xchg_wa_a", {29'd0, wa[6]}, 32'd2);
        chk("xchg_wd_a", {24'd0, wd[6]}, 32'h34);
        chk("xchg_wa_b", {29'd0, wa[7]}, 32'd5);
        chk("xchg_wd_b", {24'd0, wd[7]}, 32'h12);
        chk("xchg_r2",   {24'd0, rf[2]}, 32'h34);
        chk("xchg_r5",   {24'd0, rf[5]}, 32'h12);

        start_op(OP_MVI, 3'd7, 3'd4, 8'h3C);
        trace(1'b0);
        chk("mvi_we",    {21'd0, m_we},   32'h002);
        chk("mvi_done",  {21'd0, m_done}, 32'h004);
        chk("mvi_raddr_mask", {21'd0, m_rd}, 32'h000);
        chk("mvi_waddr", {29'd0, wa[1]}, 32'd7);
        chk("mvi_wdata", {24'd0, wd[1]}, 32'h3C);
        chk("mvi_r7",    {24'd0, rf[7]}, 32'h3C);

        start_op(4'b0000, 3'd6, 3'd6, 8'h77);
        trace(1'b0);
        chk("bad_we",    {21'd0, m_we},    32'h000);
        chk("bad_done",  {21'd0, m_done},  32'h002);
        chk("bad_err",   {21'd0, m_err},   32'h002);
        chk("bad_ready", {21'd0, m_ready}, 32'h7FC);
        start_op(OP_MVI, 3'd6, 3'd0, 8'h5A);
        trace(1'b0);
        chk("after_bad_done", {21'd0, m_done}, 32'h004);
        chk("after_bad_r6",   {24'd0, rf[6]}, 32'h5A);

        start_op(OP_MOV, 3'd4, 3'd3, 8'h00);
        trace(1'b1);
        chk("hold_ready", {21'd0, m_ready}, 32'h080);
        chk("hold_we",    {21'd0, m_we},    32'h020);
        chk("hold_waddr", {29'd0, wa[5]}, 32'd4);
        chk("hold_wdata", {24'd0, wd[5]}, 32'hA5);
        i_instr_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("hold_r4", {24'd0, rf[4]}, 32'hA5);
        chk("hold_r0", {24'd0, rf[0]}, 32'hA5);

        start_op(OP_XCHG, 3'd2, 3'd5, 8'h00);
        i_instr_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_pre", {31'd0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_we",   {31'd0, o_rf_we}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("abort_we_late", {31'd0, o_rf_we}, 32'd0);
        chk("abort_r2", {24'd0, rf[2]}, 32'h34);
        chk("abort_r5", {24'd0, rf[5]}, 32'h12);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_op(OP_MOV, 3'd3, 3'd2, 8'h00);
        trace(1'b0);
        chk("post_rst_we",   {21'd0, m_we},   32'h020);
        chk("post_rst_done", {21'd0, m_done}, 32'h040);
        chk("post_rst_r3",   {24'd0, rf[3]}, 32'h34);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
